hex_display_capture: RTL and testbench

Receive-side companion to the multiplier's multiplexed hex display driver. The block samples the active-low `hex_seg`/`hex_grid` bus, waits for each scanned digit to settle, and decodes the segment pattern back to a nibble. It then publishes the reassembled 16-bit word, matching `{Aval,Bval}`, so benches and on-board self-check logic can read what the display actually shows.

---
 rtl/hex_display_capture_if.sv | 21 ++
 rtl/hex_display_capture.sv | 176 +++++++++++++++++
 tb/tb_hex_display_capture.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hex_display_capture_if.sv
// Bus between a multiplexed hex display (active-low segments and grid)
// and the capture block, including the capture block's decoded results.
interface hex_display_capture_if;
    logic [7:0]  hex_seg;
    logic [3:0]  hex_grid;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        seg_error;
    logic [3:0]  dp;

    modport master (
        output hex_seg, hex_grid,
        input  value, digit_valid, frame_done, seg_error, dp
    );

    modport slave (
        input  hex_seg, hex_grid,
        output value, digit_valid, frame_done, seg_error, dp
    );
endinterface

// File: rtl/hex_display_capture.sv
// Samples a scanned active-low hex display, debounces each digit and rebuilds the 16-bit word.
// Optional HEX_CAPTURE_DP_EN: capture per-digit decimal points and publish them on dp.
//
// state | meaning
// IDLE  | grid blank or multi-select, nothing tracked
// TRACK | valid digit selected, counting identical samples
// HOLD  | digit accepted, waiting for the bus to change
module hex_display_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input logic Clk,
    input logic Reset,
    hex_display_capture_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef HEX_CAPTURE_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEG_W-1:0] seg_q;
    logic [3:0]       grid_q;
    logic [15:0]      value_shadow;
    logic [15:0]      value_r;
    logic [3:0]       digit_valid_r;
    logic             frame_done_r;
    logic             seg_error_r;

    logic [SEG_W-1:0] seg_in;
    logic             sample_change;
    logic             grid_in_valid;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic [4:0]       dec;
    logic [1:0]       idx;
    logic [3:0]       valid_set;

    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h40:   decode_seg = 5'h10;
            7'h79:   decode_seg = 5'h11;
            7'h24:   decode_seg = 5'h12;
            7'h30:   decode_seg = 5'h13;
            7'h19:   decode_seg = 5'h14;
            7'h12:   decode_seg = 5'h15;
            7'h02:   decode_seg = 5'h16;
            7'h78:   decode_seg = 5'h17;
            7'h00:   decode_seg = 5'h18;
            7'h10:   decode_seg = 5'h19;
            7'h08:   decode_seg = 5'h1A;
            7'h03:   decode_seg = 5'h1B;
            7'h46:   decode_seg = 5'h1C;
            7'h21:   decode_seg = 5'h1D;
            7'h06:   decode_seg = 5'h1E;
            7'h0E:   decode_seg = 5'h1F;
            default: decode_seg = 5'h00;
        endcase
    endfunction

    function automatic logic grid_ok(input logic [3:0] g);
        grid_ok = (g == 4'b1110) || (g == 4'b1101) || (g == 4'b1011) || (g == 4'b0111);
    endfunction

    function automatic logic [1:0] grid_idx(input logic [3:0] g);
        case (g)
            4'b1101: grid_idx = 2'd1;
            4'b1011: grid_idx = 2'd2;
            4'b0111: grid_idx = 2'd3;
            default: grid_idx = 2'd0;
        endcase
    endfunction

    // The FSM compares the sample being captured this edge against the one
    // already held, so the first sample of a new pattern counts as 1.
    assign seg_in        = bus.hex_seg[SEG_W-1:0];
    assign sample_change = {bus.hex_grid, seg_in} != {grid_q, seg_q};
    assign grid_in_valid = grid_ok(bus.hex_grid);
    assign cnt_inc       = (cnt == CNT_W'(STABLE_CYCLES)) ? cnt : cnt + CNT_W'(1);
    assign accept        = (state == TRACK) && !sample_change && (cnt_inc == CNT_W'(STABLE_CYCLES));
    assign dec           = decode_seg(seg_q[6:0]);
    assign idx           = grid_idx(grid_q);
    assign valid_set     = (accept && dec[4]) ? (4'b0001 << idx) : 4'b0000;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            seg_q         <= '1;
            grid_q        <= 4'hF;
            value_shadow  <= '0;
            value_r       <= '0;
            digit_valid_r <= '0;
            frame_done_r  <= 1'b0;
            seg_error_r   <= 1'b0;
        end else begin
            seg_q  <= seg_in;
            grid_q <= bus.hex_grid;

            if (digit_valid_r == 4'hF) begin
                value_r       <= value_shadow;
                frame_done_r  <= 1'b1;
                digit_valid_r <= valid_set;
            end else begin
                frame_done_r  <= 1'b0;
                digit_valid_r <= digit_valid_r | valid_set;
            end

            if (accept && dec[4])
                value_shadow[{idx, 2'b00} +: 4] <= dec[3:0];
            if (accept && !dec[4])
                seg_error_r <= 1'b1;

            case (state)
                IDLE: begin
                    if (grid_in_valid) begin
                        state <= TRACK;
                        cnt   <= CNT_W'(1);
                    end
                end
                TRACK: begin
                    if (sample_change) begin
                        state <= grid_in_valid ? TRACK : IDLE;
                        cnt   <= grid_in_valid ? CNT_W'(1) : '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(STABLE_CYCLES))
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (sample_change) begin
                        state <= grid_in_valid ? TRACK : IDLE;
                        cnt   <= grid_in_valid ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HEX_CAPTURE_DP_EN
    logic [3:0] dp_shadow;
    logic [3:0] dp_r;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dp_shadow <= '0;
            dp_r      <= '0;
        end else begin
            if (digit_valid_r == 4'hF)
                dp_r <= ~dp_shadow;
            if (accept && dec[4])
                dp_shadow[idx] <= seg_q[7];
        end
    end

    assign bus.dp = dp_r;
`else
    assign bus.dp = 4'b0000;
`endif

    assign bus.value       = value_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.seg_error   = seg_error_r;

endmodule

// File: tb/tb_hex_display_capture.sv
// Directed bench for hex_display_capture: vector table plus hand-written corner sequences.
module tb_hex_display_capture;

    logic Clk;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    int   fd_cnt = 0;

    hex_display_capture_if bus();

    hex_display_capture #(.STABLE_CYCLES(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (bus.frame_done === 1'b1) fd_cnt++;

    typedef struct {
        logic [3:0]  grid;
        logic [7:0]  seg;
        int          cyc;
        logic [3:0]  exp_valid;
        logic [15:0] exp_value;
        int          exp_fd;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [3:0] g, input logic [7:0] s, input int n);
        bus.hex_grid = g;
        bus.hex_seg  = s;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " value"},      bus.value, 16'h0000);
        chk({tag, " valid"},      {12'h0, bus.digit_valid}, 16'h0);
        chk({tag, " frame_done"}, {15'h0, bus.frame_done}, 16'h0);
        chk({tag, " seg_error"},  {15'h0, bus.seg_error}, 16'h0);
        chk({tag, " dp"},         {12'h0, bus.dp}, 16'h0);
    endtask

    initial begin
        // segment bit 7 kept high (decimal point off) throughout
        tbl[0] = '{4'b1110, 8'hB0, 8,  4'b0001, 16'h0000, 0};
        tbl[1] = '{4'b1101, 8'hA4, 8,  4'b0011, 16'h0000, 0};
        tbl[2] = '{4'b1011, 8'hF8, 8,  4'b0111, 16'h0000, 0};
        tbl[3] = '{4'b0111, 8'h92, 8,  4'b0000, 16'h5723, 1};
        tbl[4] = '{4'b1111, 8'hFF, 10, 4'b0000, 16'h5723, 1};
        tbl[5] = '{4'b1110, 8'hC0, 8,  4'b0001, 16'h5723, 1};
        tbl[6] = '{4'b1100, 8'h80, 10, 4'b0001, 16'h5723, 1};
        tbl[7] = '{4'b1101, 8'hF9, 8,  4'b0011, 16'h5723, 1};

        Reset        = 1'b1;
        bus.hex_grid = 4'b1110;
        bus.hex_seg  = 8'hB0;
        repeat (3) @(posedge Clk);
        #1;
        chk_idle_outputs("in_reset");
        Reset = 1'b0;
        put(4'b1111, 8'hFF, 3);
        chk_idle_outputs("after_release");

        for (int i = 0; i < 8; i++) begin
            put(tbl[i].grid, tbl[i].seg, tbl[i].cyc);
            chk($sformatf("v%0d valid", i), {12'h0, bus.digit_valid}, {12'h0, tbl[i].exp_valid});
            chk($sformatf("v%0d value", i), bus.value, tbl[i].exp_value);
            chk($sformatf("v%0d frames", i), 16'(fd_cnt), 16'(tbl[i].exp_fd));
            chk($sformatf("v%0d seg_error", i), {15'h0, bus.seg_error}, 16'h0);
        end

        // reset in the middle of a frame, asserted between clock edges
        put(4'b1011, 8'hC0, 8);
        chk("mid valid pre", {12'h0, bus.digit_valid}, 16'h0007);
        @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        chk("mid reset valid", {12'h0, bus.digit_valid}, 16'h0);
        chk("mid reset value", bus.value, 16'h0000);
        @(posedge Clk);
        #1 Reset = 1'b0;
        put(4'b1110, 8'hC0, 8);
        put(4'b1101, 8'hC0, 8);
        put(4'b1011, 8'hC0, 8);
        put(4'b0111, 8'hC0, 8);
        chk("zero frame value", bus.value, 16'h0000);
        chk("zero frame valid", {12'h0, bus.digit_valid}, 16'h0);
        chk("zero frame frames", 16'(fd_cnt), 16'd2);

        // glitch: "1" for 3 samples, then "8"; accept exactly 3 edges after the first 8 sample
        put(4'b1101, 8'hF9, 3);
        chk("glitch short 1", {12'h0, bus.digit_valid}, 16'h0);
        put(4'b1101, 8'h80, 3);
        chk("glitch before accept", {12'h0, bus.digit_valid}, 16'h0);
        put(4'b1101, 8'h80, 1);
        chk("glitch accept edge", {12'h0, bus.digit_valid}, 16'h0002);
        put(4'b1101, 8'h80, 4);
        put(4'b1110, 8'hC0, 8);
        put(4'b1011, 8'hC0, 8);
        put(4'b0111, 8'hC0, 8);
        chk("glitch frame value", bus.value, 16'h0080);
        chk("glitch frames", 16'(fd_cnt), 16'd3);

        // undecodable blank pattern sets a sticky error without capturing
        put(4'b1110, 8'hFF, 6);
        chk("bad seg_error", {15'h0, bus.seg_error}, 16'h1);
        chk("bad valid", {12'h0, bus.digit_valid}, 16'h0);
        put(4'b1110, 8'h86, 8);
        put(4'b1101, 8'hA1, 8);
        put(4'b1011, 8'hC6, 8);
        put(4'b0111, 8'h83, 8);
        chk("bad frame value", bus.value, 16'hBCDE);
        chk("bad frames", 16'(fd_cnt), 16'd4);
        chk("bad error sticky", {15'h0, bus.seg_error}, 16'h1);
        chk("dp default", {12'h0, bus.dp}, 16'h0);

        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        chk("final error cleared", {15'h0, bus.seg_error}, 16'h0);
        chk("final value cleared", bus.value, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
